// File: rtl/dual_lane_dispatcher.sv
// dual_lane_dispatcher: steers fetched instructions into two lane FIFOs using overrides, a register ownership scoreboard and lane occupancy.
// Define DISPATCH_STATS_EN to add saturating issue_cnt1/issue_cnt2/stall_cnt outputs.
`timescale 1ns/1ps
module dual_lane_dispatcher #(
    parameter int DEPTH  = 8,
    parameter int PEND_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        fifo1_pop,
    input  logic        fifo2_pop,
    input  logic        wb1_en,
    input  logic [4:0]  wb1_addr,
    input  logic        wb2_en,
    input  logic [4:0]  wb2_addr,
    output logic        FIFO_1_en,
    output logic        FIFO_2_en,
    output logic [31:0] instr_out,
`ifdef DISPATCH_STATS_EN
    output logic [15:0] issue_cnt1,
    output logic [15:0] issue_cnt2,
    output logic [15:0] stall_cnt,
`endif
    output logic        dep_stall
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);
    localparam logic [PEND_W-1:0] PMAX = '1;

    typedef enum logic [1:0] {ISSUE, STALL_FULL, STALL_DEP} state_t;

    state_t state;
    logic [PEND_W-1:0] cnt [32];
    logic [31:0] owner;
    logic [31:0] inc;
    logic [31:0] dec;
    logic [OW-1:0] occ1;
    logic [OW-1:0] occ2;
    logic rr_next;

    logic [1:0] ovr;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic [4:0] dest;
    logic own_a;
    logic own_b;
    logic own_d;
    logic any_own;
    logic forced;
    logic conflict;
    logic dep_conf;
    logic dep_lane;
    logic bal_lane;
    logic balanced;
    logic lane;
    logic room;
    logic dest_ok;
    logic acc;

    assign ovr   = instr[28:27];
    assign src_a = instr[20:16];
    assign src_b = instr[15:11];
    assign dest  = instr[4:0];

    // Register 0 is never tracked, so it can never own or conflict.
    assign own_a   = src_a != 5'd0 && cnt[src_a] != '0;
    assign own_b   = src_b != 5'd0 && cnt[src_b] != '0;
    assign own_d   = dest  != 5'd0 && cnt[dest]  != '0;
    assign any_own = own_a || own_b || own_d;

    assign conflict = (own_a && own_b && owner[src_a] != owner[src_b]) ||
                      (own_a && own_d && owner[src_a] != owner[dest]) ||
                      (own_b && own_d && owner[src_b] != owner[dest]);

    assign forced   = ovr[1];
    assign dep_conf = !forced && conflict;
    assign dep_lane = own_a ? owner[src_a] : own_b ? owner[src_b] : owner[dest];
    assign bal_lane = occ1 < occ2 ? 1'b0 : occ2 < occ1 ? 1'b1 : rr_next;
    assign balanced = !forced && !any_own;
    assign lane     = forced ? ovr[0] : any_own ? dep_lane : bal_lane;

    assign room     = (lane ? occ2 : occ1) < FULL;
    assign dest_ok  = dest == 5'd0 || cnt[dest] != PMAX;
    assign in_ready = !reset && !dep_conf && room && dest_ok;
    assign acc      = in_valid && in_ready;
    assign dep_stall = state == STALL_DEP;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 1; i < 32; i++) begin
            inc[i] = acc && dest == 5'(i);
            dec[i] = cnt[i] != '0 && ((wb1_en && wb1_addr == 5'(i) && !owner[i]) ||
                                      (wb2_en && wb2_addr == 5'(i) && owner[i]));
        end
    end

    // A same-cycle accept and matching retire cancel in the count, while the owner moves to the new lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (reset || i == 0) begin
                cnt[i]   <= '0;
                owner[i] <= 1'b0;
            end else begin
                cnt[i] <= cnt[i] + PEND_W'(inc[i]) - PEND_W'(dec[i]);
                if (inc[i])
                    owner[i] <= lane;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ISSUE;
            FIFO_1_en <= 1'b0;
            FIFO_2_en <= 1'b0;
            instr_out <= '0;
            occ1      <= '0;
            occ2      <= '0;
            rr_next   <= 1'b0;
        end else begin
            state     <= (in_valid && dep_conf) ? STALL_DEP :
                         (in_valid && !in_ready) ? STALL_FULL : ISSUE;
            FIFO_1_en <= acc && !lane;
            FIFO_2_en <= acc && lane;
            if (acc)
                instr_out <= instr;
            if (acc && balanced)
                rr_next <= !rr_next;
            occ1 <= occ1 + OW'(acc && !lane) - OW'(fifo1_pop && occ1 != '0);
            occ2 <= occ2 + OW'(acc && lane) - OW'(fifo2_pop && occ2 != '0);
        end
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt1 <= '0;
            issue_cnt2 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (FIFO_1_en && issue_cnt1 != 16'hffff)
                issue_cnt1 <= issue_cnt1 + 16'd1;
            if (FIFO_2_en && issue_cnt2 != 16'hffff)
                issue_cnt2 <= issue_cnt2 + 16'd1;
            if (in_valid && !in_ready && stall_cnt != 16'hffff)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule
